// File: rtl/sync_sport_ram_pkg.sv
// Shared types and constants for the synchronous single-port RAM slice:
// clear-sequencer states and the read-during-write mode selectors.
package sync_sport_ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/sync_sport_ram_if.sv
// Access bus of the single-port RAM: request side driven by the master,
// result/valid/busy returned by the RAM (slave).
interface sync_sport_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic                  en;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;
    logic                  busy;

    modport master (output en, we, addr, wdata, be, input rdata, rvalid, busy);
    modport slave  (input en, we, addr, wdata, be, output rdata, rvalid, busy);
endinterface

// File: rtl/sync_sport_ram_core.sv
// Storage array with byte-enable writes and a single registered read stage
// whose result is either the old word or the byte-merged new word.
module sport_ram_core
    import sync_sport_ram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] old_s;
    logic [DATA_W-1:0] merged_s;

    // Old word and its byte-merged update
    always_comb begin
        old_s    = mem[addr];
        merged_s = old_s;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                merged_s[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                merged_s[8*b +: 8] = old_s[8*b +: 8];
            end
        end
    end

    // Array write; disabled bytes are rewritten with their own value
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= merged_s;
        end
    end

    // Registered read result, held between accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            if ((RDW_MODE == RDW_WRITE_FIRST) && wr_en) begin
                rdata <= merged_s;
            end else begin
                rdata <= old_s;
            end
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: rtl/sync_sport_ram.sv
// Single-port RAM top: post-reset zero-fill sequencer, clear/user port mux,
// optional second read stage and the rvalid pipeline.
module sync_sport_ram
    import sync_sport_ram_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic           clk,
    input  logic           rst,
    sync_sport_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("sync_sport_ram: DATA_W must be a multiple of 8");
    end
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
        $error("sync_sport_ram: RD_LAT must be 1 or 2");
    end

    state_e                state_r;
    state_e                state_next_s;
    logic [ADDR_W-1:0]     clr_addr_r;
    logic                  busy_s;
    logic                  clr_we_s;
    logic                  acc_s;
    logic                  core_wr_s;
    logic [ADDR_W-1:0]     core_addr_s;
    logic [DATA_W-1:0]     core_wdata_s;
    logic [DATA_W/8-1:0]   core_be_s;
    logic [DATA_W-1:0]     core_rdata_s;
    logic [RD_LAT-1:0]     vld_r;

    // State register and clear address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            clr_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_CLEAR) begin
                clr_addr_r <= clr_addr_r + ADDR_W'(1);
            end else begin
                clr_addr_r <= clr_addr_r;
            end
        end
    end

    // Next state: leave the clear once the last word has been written
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_addr_r == ADDR_W'(DEPTH - 1)) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: state_next_s = ST_READY;
            default:  state_next_s = ST_READY;
        endcase
    end

    // State outputs; reset suppresses the clear write on its own edge
    always_comb begin
        busy_s   = 1'b0;
        clr_we_s = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                busy_s   = 1'b1;
                clr_we_s = !rst;
            end
            ST_READY: begin
                busy_s   = 1'b0;
                clr_we_s = 1'b0;
            end
            default: begin
                busy_s   = 1'b0;
                clr_we_s = 1'b0;
            end
        endcase
    end

    assign acc_s = bus.en && !busy_s && !rst;

    // Core port mux: clear sequencer has priority while busy
    always_comb begin
        if (clr_we_s) begin
            core_wr_s    = 1'b1;
            core_addr_s  = clr_addr_r;
            core_wdata_s = {DATA_W{1'b0}};
            core_be_s    = {(DATA_W/8){1'b1}};
        end else begin
            core_wr_s    = acc_s && bus.we;
            core_addr_s  = bus.addr;
            core_wdata_s = bus.wdata;
            core_be_s    = bus.be;
        end
    end

    sport_ram_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RDW_MODE (RDW_MODE)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .wr_en (core_wr_s),
        .rd_en (acc_s),
        .addr  (core_addr_s),
        .wdata (core_wdata_s),
        .be    (core_be_s),
        .rdata (core_rdata_s)
    );

    // rvalid shift register, flushed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {RD_LAT{1'b0}};
        end else begin
            vld_r <= RD_LAT'({vld_r, acc_s});
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rdata2_r;

        // Second read stage advances only with a valid first-stage result
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata2_r <= {DATA_W{1'b0}};
            end else if (vld_r[0]) begin
                rdata2_r <= core_rdata_s;
            end else begin
                rdata2_r <= rdata2_r;
            end
        end
        assign bus.rdata = rdata2_r;
    end else begin : g_lat1
        assign bus.rdata = core_rdata_s;
    end

    assign bus.rvalid = vld_r[RD_LAT-1];
    assign bus.busy   = busy_s;

endmodule

// File: tb/tb_sync_sport_ram.sv
// Bench: four configurations (RD_LAT 1/2 x RDW_MODE 0/1) driven in lockstep,
// checked against an array/queue reference model and directed expectations.
module tb_sync_sport_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [15:0] wdata = 16'h0000;
    logic [1:0]  be = 2'b00;

    logic [15:0] rdata_a [4];
    logic [3:0]  rvalid_v;
    logic [3:0]  busy_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        sync_sport_ram_if #(.DATA_W(16), .ADDR_W(3)) bus();
        assign bus.en    = en;
        assign bus.we    = we;
        assign bus.addr  = addr;
        assign bus.wdata = wdata;
        assign bus.be    = be;
        assign rdata_a[g]  = bus.rdata;
        assign rvalid_v[g] = bus.rvalid;
        assign busy_v[g]   = bus.busy;

        sync_sport_ram #(
            .DATA_W(16), .ADDR_W(3), .RD_LAT((g % 2) + 1),
            .RDW_MODE(g / 2), .CLEAR_ON_RST(1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    typedef struct {
        bit          rst;
        bit          en;
        bit          we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        bit          dchk;
        logic [15:0] d0;
        logic [15:0] d1;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] data;
        bit          dchk;
        logic [15:0] ddata;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbq [4][$];
    logic [15:0] mdl [8];
    logic [15:0] last_rd [4];
    int          busy_left = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic vec_t mk(bit r, bit e, bit w, int a, int wd, int b, bit dc, int d0, int d1);
        vec_t v;
        v.rst = r; v.en = e; v.we = w; v.addr = 3'(a); v.wdata = 16'(wd);
        v.be = 2'(b); v.dchk = dc; v.d0 = 16'(d0); v.d1 = 16'(d1);
        return v;
    endfunction

    task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d cycle %0d: got %h, expected %h", name, g, cyc, act, exp);
        end
    endtask

    task automatic step(vec_t v);
        logic [15:0] old_w;
        logic [15:0] new_w;
        exp_t        e;
        bit          exp_v;
        rst = v.rst; en = v.en; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be;
        @(posedge clk);
        cyc++;
        if (v.rst) begin
            for (int g = 0; g < 4; g++) begin
                sbq[g].delete();
                last_rd[g] = 16'h0000;
            end
            for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
            busy_left = 8;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (v.en) begin
            old_w = mdl[v.addr];
            new_w = old_w;
            for (int b = 0; b < 2; b++) begin
                if (v.be[b]) new_w[8*b +: 8] = v.wdata[8*b +: 8];
            end
            if (v.we) mdl[v.addr] = new_w;
            for (int g = 0; g < 4; g++) begin
                e.due   = cyc + (g % 2);
                e.data  = (v.we && (g / 2 == 1)) ? new_w : old_w;
                e.dchk  = v.dchk;
                e.ddata = (g / 2 == 1) ? v.d1 : v.d0;
                sbq[g].push_back(e);
            end
        end
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("busy", g, 32'(busy_v[g]), 32'(busy_left > 0));
            exp_v = (sbq[g].size() > 0) && (sbq[g][0].due == cyc);
            chk("rvalid", g, 32'(rvalid_v[g]), 32'(exp_v));
            if (exp_v) begin
                e = sbq[g].pop_front();
                chk("rdata", g, 32'(rdata_a[g]), 32'(e.data));
                if (e.dchk) chk("directed", g, 32'(rdata_a[g]), 32'(e.ddata));
                last_rd[g] = e.data;
            end else begin
                chk("rdata_hold", g, 32'(rdata_a[g]), 32'(last_rd[g]));
            end
        end
    endtask

    initial begin
        vec_t v;
        // Reset, then a dropped write during the first busy cycle
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3, 16'hFFFF, 3, 0, 0, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Clean image after clear
        for (int l = 0; l < 8; l++) vecs.push_back(mk(0, 1, 0, l, 0, 0, 1, 0, 0));
        // Fill and read back-to-back
        for (int l = 0; l < 8; l++) vecs.push_back(mk(0, 1, 1, l, l * 16'h1111, 3, 0, 0, 0));
        for (int l = 0; l < 8; l++) vecs.push_back(mk(0, 1, 0, l, 0, 0, 1, l * 16'h1111, l * 16'h1111));
        // Partial byte write
        vecs.push_back(mk(0, 1, 1, 2, 16'hABCD, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 16'h12FF, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 0, 0, 1, 16'h12CD, 16'h12CD));
        // Read-during-write result
        vecs.push_back(mk(0, 1, 1, 5, 16'h0055, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 16'h00AA, 3, 1, 16'h0055, 16'h00AA));
        vecs.push_back(mk(0, 1, 0, 5, 0, 0, 1, 16'h00AA, 16'h00AA));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // In-flight read flushed by reset, then reset at clear count 4
        vecs.push_back(mk(0, 1, 0, 7, 0, 0, 1, 16'h7777, 16'h7777));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 16'h5A5A, 3, 0, 0, 0));
        for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 1, 0, i % 8, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            v = mk(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 3), 0, 0, 0);
            step(v);
        end
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int g = 0; g < 4; g++) chk("drain", g, 32'(sbq[g].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
